// File: rtl/fas_freq_analyzer_pkg.sv
// Shared types and constants for the FAS frequency analyzer slice.
package fas_pkg;

  // Component width (signed Q8.8), bins per frame, bin index width.
  localparam int DW   = 16;
  localparam int NBIN = 16;
  localparam int IW   = 4;

  // Power width: two squared DW-bit terms summed, kept unsigned.
  localparam int PW   = 2 * DW;

  // Index of the final bin in a frame; the scan ends on this index.
  localparam logic [IW-1:0] LAST_IDX = IW'(NBIN - 1);

  // One complex bin, laid out to match the bus word: [31:16] re, [15:0] im.
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  // A whole frame; element k is bin k.
  typedef cplx_t [NBIN-1:0] bin_frame_t;

  // Analyzer control states.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } ana_state_t;

endpackage

// File: rtl/fas_freq_analyzer_if.sv
// FFT output bus: a frame strobe plus 16 parallel complex bins.
//
// Handshake: fft_valid is a single-cycle strobe with no ready/backpressure.
// The master may present a frame on any cycle; fft_d0..fft_d15 are only
// meaningful in cycles where fft_valid is high. The slave holds one frame
// being scanned plus one pending frame; anything beyond that is dropped and
// flagged by the slave, never stalled.
interface fas_freq_analyzer_if;
  import fas_pkg::*;

  logic          fft_valid;
  logic [PW-1:0] fft_d0;
  logic [PW-1:0] fft_d1;
  logic [PW-1:0] fft_d2;
  logic [PW-1:0] fft_d3;
  logic [PW-1:0] fft_d4;
  logic [PW-1:0] fft_d5;
  logic [PW-1:0] fft_d6;
  logic [PW-1:0] fft_d7;
  logic [PW-1:0] fft_d8;
  logic [PW-1:0] fft_d9;
  logic [PW-1:0] fft_d10;
  logic [PW-1:0] fft_d11;
  logic [PW-1:0] fft_d12;
  logic [PW-1:0] fft_d13;
  logic [PW-1:0] fft_d14;
  logic [PW-1:0] fft_d15;

  modport master (
    output fft_valid,
    output fft_d0, fft_d1, fft_d2,  fft_d3,  fft_d4,  fft_d5,  fft_d6,  fft_d7,
    output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15
  );

  modport slave (
    input fft_valid,
    input fft_d0, fft_d1, fft_d2,  fft_d3,  fft_d4,  fft_d5,  fft_d6,  fft_d7,
    input fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15
  );

endinterface

// File: rtl/fas_freq_analyzer_bin_power.sv
// Combinational bin power: re^2 + im^2 as an unsigned PW-bit value.
// The largest input (-2^15, -2^15) gives 2^30 + 2^30 = 2^31, which still
// fits in 32 unsigned bits, so the sum never wraps.
module fas_bin_power
  import fas_pkg::*;
(
  input  cplx_t         bin,
  output logic [PW-1:0] power
);

  logic signed [PW-1:0] re_x;
  logic signed [PW-1:0] im_x;
  logic signed [PW-1:0] re_sq;
  logic signed [PW-1:0] im_sq;

  // Sign-extend before multiplying so the square is computed at full width.
  assign re_x  = {{DW{bin.re[DW-1]}}, bin.re};
  assign im_x  = {{DW{bin.im[DW-1]}}, bin.im};

  // Each square is at most 2^30, so it is non-negative in PW signed bits.
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  // Sum as unsigned: 2^31 would be negative if read back as signed.
  assign power = unsigned'(re_sq) + unsigned'(im_sq);

endmodule

// File: rtl/fas_freq_analyzer.sv
// FAS frequency analyzer: captures 16-bin FFT frames, scans one bin per
// cycle computing re^2+im^2, and reports the strongest bin index with a
// one-cycle done pulse. One pending frame may queue behind the frame being
// scanned; a further frame is dropped and sets the sticky overflow flag.
module fas_freq_analyzer
  import fas_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fas_freq_analyzer_if.slave  fft,
  output logic                done,
  output logic [IW-1:0]       freq,
  output logic [PW-1:0]       peak_mag,
  output logic                busy,
  output logic                overflow,
  output ana_state_t          dbg_state
);

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  ana_state_t    state_q;
  ana_state_t    state_d;
  logic [IW-1:0] idx_q;
  bin_frame_t    work_q;
  bin_frame_t    pend_q;
  logic          pend_vld_q;
  logic [PW-1:0] max_q;
  logic [IW-1:0] maxidx_q;
  logic          done_q;
  logic [IW-1:0] freq_q;
  logic [PW-1:0] peak_q;
  logic          busy_q;
  logic          ovf_q;

  // Control decisions for the current cycle.
  logic          load_new;
  logic          load_pend;
  logic          pend_store;
  logic          pend_clear;
  logic          drop;
  logic          scan_en;
  logic          last;

  // Per-bin datapath.
  bin_frame_t    in_frame;
  cplx_t         cur_bin;
  logic [PW-1:0] cur_pwr;
  logic          take;
  logic [PW-1:0] max_nx;
  logic [IW-1:0] maxidx_nx;

  // Bus words map straight onto cplx_t: [31:16] re, [15:0] im.
  assign in_frame = {fft.fft_d15, fft.fft_d14, fft.fft_d13, fft.fft_d12,
                     fft.fft_d11, fft.fft_d10, fft.fft_d9,  fft.fft_d8,
                     fft.fft_d7,  fft.fft_d6,  fft.fft_d5,  fft.fft_d4,
                     fft.fft_d3,  fft.fft_d2,  fft.fft_d1,  fft.fft_d0};

  assign scan_en = (state_q == SCAN);
  assign last    = scan_en && (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------
  // Bin power and running maximum
  // ---------------------------------------------------------------------
  assign cur_bin = work_q[idx_q];

  fas_bin_power u_bin_power (
    .bin   (cur_bin),
    .power (cur_pwr)
  );

  // Bin 0 always seeds the maximum; later bins win only if strictly larger,
  // so ties resolve to the lowest index.
  assign take      = (idx_q == '0) || (cur_pwr > max_q);
  assign max_nx    = take ? cur_pwr : max_q;
  assign maxidx_nx = take ? idx_q   : maxidx_q;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave SCAN only when the last bin is done and nothing waits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fft.fft_valid) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (last && !pend_vld_q && !fft.fft_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame routing: where an arriving frame goes, and whether it is dropped.
  always_comb begin
    load_new   = 1'b0;
    load_pend  = 1'b0;
    pend_store = 1'b0;
    pend_clear = 1'b0;
    drop       = 1'b0;
    case (state_q)
      IDLE: begin
        load_new = fft.fft_valid;
      end
      SCAN: begin
        if (last) begin
          if (pend_vld_q) begin
            // Pending frame moves up; a frame arriving now refills pending.
            load_pend = 1'b1;
            if (fft.fft_valid) begin
              pend_store = 1'b1;
            end else begin
              pend_clear = 1'b1;
            end
          end else if (fft.fft_valid) begin
            // Arrival on the last bin feeds the next scan directly: no bubble.
            load_new = 1'b1;
          end
        end else if (fft.fft_valid) begin
          if (!pend_vld_q) begin
            pend_store = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------

  // Working array and one-deep pending buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      work_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      if (load_new) begin
        work_q <= in_frame;
      end else if (load_pend) begin
        work_q <= pend_q;
      end
      if (pend_store) begin
        pend_q     <= in_frame;
        pend_vld_q <= 1'b1;
      end else if (pend_clear) begin
        pend_q     <= '0;
        pend_vld_q <= 1'b0;
      end
    end
  end

  // Scan index and running maximum; the index wraps to 0 after the last bin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q    <= '0;
      max_q    <= '0;
      maxidx_q <= '0;
    end else if (scan_en) begin
      idx_q    <= idx_q + 1'b1;
      max_q    <= max_nx;
      maxidx_q <= maxidx_nx;
    end else if (load_new) begin
      idx_q    <= '0;
      max_q    <= '0;
      maxidx_q <= '0;
    end
  end

  // Result registers: updated on the last bin, including that bin's compare.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q <= 1'b0;
      freq_q <= '0;
      peak_q <= '0;
    end else begin
      done_q <= last;
      if (last) begin
        freq_q <= maxidx_nx;
        peak_q <= max_nx;
      end
    end
  end

  // Status flags: busy mirrors the registered state, overflow is sticky.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= (state_d == SCAN);
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign done      = done_q;
  assign freq      = freq_q;
  assign peak_mag  = peak_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fas_freq_analyzer.sv
// Bench for fas_freq_analyzer: directed frames, scoreboard of expected
// done cycle / freq / peak_mag, monitor popping on every done pulse.
module tb_fas_freq_analyzer;
  import fas_pkg::*;

  localparam int W = 68;  // {done cycle[31:0], freq[3:0], peak_mag[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  fas_freq_analyzer_if fft_bus ();

  logic          done;
  logic [IW-1:0] freq;
  logic [PW-1:0] peak_mag;
  logic          busy;
  logic          overflow;
  ana_state_t    dbg_state;

  fas_freq_analyzer dut (
    .clk       (clk),
    .rst       (rst),
    .fft       (fft_bus.slave),
    .done      (done),
    .freq      (freq),
    .peak_mag  (peak_mag),
    .busy      (busy),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [31:0]  frm [NBIN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < NBIN; i++) frm[i] = v;
  endtask

  task automatic drive_bus(input logic v);
    fft_bus.fft_valid = v;
    fft_bus.fft_d0  = frm[0];  fft_bus.fft_d1  = frm[1];
    fft_bus.fft_d2  = frm[2];  fft_bus.fft_d3  = frm[3];
    fft_bus.fft_d4  = frm[4];  fft_bus.fft_d5  = frm[5];
    fft_bus.fft_d6  = frm[6];  fft_bus.fft_d7  = frm[7];
    fft_bus.fft_d8  = frm[8];  fft_bus.fft_d9  = frm[9];
    fft_bus.fft_d10 = frm[10]; fft_bus.fft_d11 = frm[11];
    fft_bus.fft_d12 = frm[12]; fft_bus.fft_d13 = frm[13];
    fft_bus.fft_d14 = frm[14]; fft_bus.fft_d15 = frm[15];
  endtask

  // One-cycle fft_valid pulse, called on a negedge; returns one negedge later.
  // lat = cycles from this negedge to the negedge where done is expected.
  task automatic pulse(input logic push, input logic [3:0] f,
                       input logic [31:0] m, input int lat);
    drive_bus(1'b1);
    if (push) exp_q.push_back({32'(cyc + lat), f, m});
    @(negedge clk);
    fft_bus.fft_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been seen.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  // Every done pulse must match the head of the expected queue.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 freq=%0d at cycle %0d, want no done",
                 freq, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), e[67:36]);
        chk("freq", 32'(freq), 32'(e[35:32]));
        chk("peak_mag", peak_mag, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    fill(32'h0);
    drive_bus(1'b0);

    // Reset held for 3 cycles.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_freq", 32'(freq), 32'd0);
    chk("rst_peak", peak_mag, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // Single frame: bin 5 = (3.0, -3.0) -> 2*768^2 = 0x120000; others 0x10000.
    fill(32'h0100_0000);
    frm[5] = 32'h0300_FD00;
    pulse(1'b1, 4'd5, 32'h0012_0000, 17);
    chk("busy_in_scan", 32'(busy), 32'd1);
    drain(40);
    chk("busy_after_scan", 32'(busy), 32'd0);

    // Tie: bins 2 and 9 both (-128, 0) -> 2^30; lowest index wins.
    fill(32'h0);
    frm[2] = 32'h8000_0000;
    frm[9] = 32'h8000_0000;
    pulse(1'b1, 4'd2, 32'h4000_0000, 17);
    drain(40);

    // Extremes: every bin (-128, -128) -> 2^31, no wrap, tie -> bin 0.
    fill(32'h8000_8000);
    pulse(1'b1, 4'd0, 32'h8000_0000, 17);
    drain(40);

    // All-zero frame.
    fill(32'h0);
    pulse(1'b1, 4'd0, 32'h0, 17);
    drain(40);

    // Back-to-back frames 16 cycles apart, maxima at 15, 0, 7.
    fill(32'h0100_0000);
    frm[15] = 32'h0200_0000;                  // 512^2 = 0x40000
    pulse(1'b1, 4'd15, 32'h0004_0000, 17);
    repeat (15) @(negedge clk);
    fill(32'h0100_0000);
    frm[0] = 32'h0400_0000;                   // 1024^2 = 0x100000
    pulse(1'b1, 4'd0, 32'h0010_0000, 17);
    repeat (15) @(negedge clk);
    fill(32'h0100_0000);
    frm[7] = 32'h0100_0100;                   // 2*256^2 = 0x20000
    pulse(1'b1, 4'd7, 32'h0002_0000, 17);
    drain(60);
    chk("b2b_overflow", 32'(overflow), 32'd0);

    // Overflow: A at 0, B at 3 (pending), C at 5 (dropped).
    fill(32'h0100_0000);
    frm[5] = 32'h0300_FD00;
    pulse(1'b1, 4'd5, 32'h0012_0000, 17);     // n0 -> n1
    @(negedge clk);                            // n2
    @(negedge clk);                            // n3
    fill(32'h0);
    frm[2] = 32'h8000_0000;
    frm[9] = 32'h8000_0000;
    pulse(1'b1, 4'd2, 32'h4000_0000, 30);     // B done 32 edges after A's E0
    chk("ovf_before_drop", 32'(overflow), 32'd0);
    @(negedge clk);                            // n5
    fill(32'h7FFF_7FFF);
    pulse(1'b0, 4'd0, 32'h0, 0);               // C, dropped -> n6
    chk("ovf_after_drop", 32'(overflow), 32'd1);
    drain(60);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-scan with a pending frame: nothing may complete.
    fill(32'h0100_0000);
    frm[3] = 32'h0500_0000;
    pulse(1'b0, 4'd0, 32'h0, 0);               // n0 -> n1
    @(negedge clk);                            // n2
    fill(32'h0100_0000);
    frm[12] = 32'h0600_0000;
    pulse(1'b0, 4'd0, 32'h0, 0);               // pending, n2 -> n3
    repeat (6) @(negedge clk);                 // n9: next edge scans idx 8
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_freq", 32'(freq), 32'd0);
    chk("mid_rst_peak", peak_mag, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));

    // Fresh frame after reset: bin 11 = (0, 1.0) -> 0x10000.
    fill(32'h0);
    frm[11] = 32'h0000_0100;
    pulse(1'b1, 4'd11, 32'h0001_0000, 17);
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by cycle %0d, want end of stimulus", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fas_freq_analyzer.md
Name: fas_freq_analyzer

Overview:
- Receive-side consumer of the FAS FFT output interface: `fft_valid` plus 16 parallel complex bins `fft_d0`..`fft_d15`.
- Captures each 16-bin frame, scans the bins serially one per cycle, and computes power = re² + im² for each bin.
- Reports the index of the strongest bin on `freq`, with a one-cycle `done` pulse.
- Forms the analysis stage behind the FFT; it feeds the `done`/`freq` outputs of the FAS top.

Parameters:
- DW, 16, width of each real/imag component (signed, 8 integer + 8 fraction).
- NBIN, 16, bins per frame. Fixed by the port list; not overridable.
- IW, 4, width of the bin index, log2(NBIN).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- fft_valid  input  1  frame strobe; `fft_d0`..`fft_d15` are valid in this cycle.
- fft_d0..fft_d15  input  32 each  bin k: [31:16] real, [15:0] imag, two's complement.
- done  output  1  one-cycle pulse; `freq`/`peak_mag` are updated this cycle.
- freq  output  4  index of the maximum-power bin of the last completed frame.
- peak_mag  output  32  unsigned re²+im² of that bin.
- busy  output  1  high while the block is in state SCAN.
- overflow  output  1  sticky; set when a frame is dropped.

Behaviour:
- Reset (`rst`==0 at an edge): state IDLE, idx=0, pending empty, all internal registers cleared. `done`=0, `freq`=0, `peak_mag`=0, `busy`=0, `overflow`=0.
- Reset mid-scan aborts the frame silently: no `done`, pending discarded.
- States: IDLE, SCAN.
- IDLE, `fft_valid`=1: load all 16 bins into the working array; idx←0, max←0, maxidx←0; go to SCAN.
- SCAN, each edge: p = re[idx]² + im[idx]², signed 16×16 products, sum kept as 32-bit unsigned.
  - Max possible sum is 2·2^30 = 2^31; it must not wrap.
  - idx==0: max←p, maxidx←0.
  - Otherwise: if p > max (strictly greater), max←p and maxidx←idx. Ties keep the lowest index.
  - idx increments.
- Final scan edge (idx==15): register `done`=1, `freq`=final maxidx, `peak_mag`=final max, including bin 15's own comparison.
- Frame latency: frame sampled at edge E0 → scan edges E1..E16 → `done` high for exactly the one cycle after E16. `freq`/`peak_mag` then hold until the next `done`.
- `fft_valid` during SCAN (idx≠15):
  - Pending empty: copy the frame into the one-deep pending buffer.
  - Pending full: drop the new frame and set `overflow`.
- Final scan edge transitions:
  - Pending valid: working←pending; stay in SCAN with idx=0. If `fft_valid` is also high this cycle, pending←new frame; otherwise pending is cleared.
  - Else if `fft_valid`: working←new frame; stay in SCAN with idx=0.
  - Else: go to IDLE.
- Sustained frames: back-to-back frames therefore produce `done` every 16 cycles with no bubble.
- `overflow` clears only on reset.
- `busy` = (state==SCAN), registered.

Decomposition:
- Package `fas_pkg`:
  - constants DW=16, NBIN=16, IW=4;
  - typedef `cplx_t` (packed struct: re, im, each signed [15:0]);
  - typedef `bin_frame_t` (array of 16 `cplx_t`);
  - enum `ana_state_t` {IDLE, SCAN}.
- One sub-module `fas_bin_power`: combinational `cplx_t` in → 32-bit unsigned power out. Instantiated once, on the working-array mux output.

Test Plan:
- Reset: hold `rst`=0 for 3 cycles, then release → `done`=0, `freq`=0, `peak_mag`=0, `busy`=0, `overflow`=0.
- Single frame: bin 5 = {re 0x0300, im 0xFD00}, all other bins 0x0100/0x0000, one `fft_valid` pulse → `done` exactly 17 cycles later; `freq`=5, `peak_mag`=0x00120000.
- Tie and extremes:
  - bins 2 and 9 both {0x8000, 0x0000}, others 0 → `freq`=2, `peak_mag`=0x40000000.
  - all bins {0x8000, 0x8000} → `freq`=0, `peak_mag`=0x80000000.
  - all-zero frame → `freq`=0, `peak_mag`=0.
- Back-to-back: three frames with maxima at bins 15, 0, 7, `fft_valid` spaced 16 cycles apart → three `done` pulses 16 cycles apart; `freq` = 15, 0, 7; `overflow`=0.
- Overflow: frame A at cycle 0, frames B and C at cycles 3 and 5 → B scanned after A; C dropped, `overflow`=1 from cycle 6. Exactly two `done` pulses, carrying A's and B's indices.
- Reset mid-scan: apply `rst`=0 at scan idx 8 with a pending frame present → no `done` at any later point; outputs return to reset values; a new frame afterwards completes normally.
